// File: rtl/kv_pkg.sv
// rtl/kv_pkg.sv - shared constants for the key-value lookup request path
package kv_pkg;

  // Default lookup key width and the width of the opcode/flag nibble
  localparam int KEY_SIZE_DEF = 96;
  localparam int FLAG_W       = 4;

  // One bit is enough to name either of the two parser ports
  localparam int PORT_W = 1;

  // Lookup status encodings carried in the DB reply flag
  localparam logic [1:0] STATUS_SUSPECT = 2'b01;
  localparam logic [1:0] STATUS_ARREST  = 2'b10;
  localparam logic [1:0] STATUS_FILTERE = 2'b11;

endpackage

// File: rtl/kv_tag_fifo.sv
// rtl/kv_tag_fifo.sv - in-order FIFO of issuing port ids for outstanding lookups
module kv_tag_fifo
  import kv_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              push_i,
  input  logic [PORT_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [PORT_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [PORT_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok;
  logic              pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  // Guard against overflow/underflow; a full FIFO refuses a push even if it pops
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // Next pointers wrap naturally; count stays put on simultaneous push and pop
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/kv_req_arbiter.sv
// rtl/kv_req_arbiter.sv - two-port round-robin sharing of one key-value DB lookup port
module kv_req_arbiter
  import kv_pkg::*;
#(
  parameter int KEY_SIZE    = KEY_SIZE_DEF,
  parameter int OUTSTANDING = 8,
  parameter int CNT_W       = 8
) (
  input  logic                clk156,
  input  logic                eth_rst_n,
  input  logic [KEY_SIZE-1:0] req0_key,
  input  logic [FLAG_W-1:0]   req0_flag,
  input  logic                req0_valid,
  input  logic [KEY_SIZE-1:0] req1_key,
  input  logic [FLAG_W-1:0]   req1_flag,
  input  logic                req1_valid,
  output logic                rsp0_valid,
  output logic [FLAG_W-1:0]   rsp0_flag,
  output logic                rsp1_valid,
  output logic [FLAG_W-1:0]   rsp1_flag,
  output logic [KEY_SIZE-1:0] db_key,
  output logic [FLAG_W-1:0]   db_flag,
  output logic                db_valid,
  input  logic                db_ready,
  input  logic                db_rsp_valid,
  input  logic [FLAG_W-1:0]   db_rsp_flag,
  output logic [CNT_W-1:0]    drop0_cnt,
  output logic [CNT_W-1:0]    drop1_cnt,
  output logic [CNT_W-1:0]    orphan_cnt,
  output logic [7:0]          debug
);

  localparam int AW = $clog2(OUTSTANDING);

  // Per-port pending slots
  logic                pend0_q, pend1_q;
  logic [KEY_SIZE-1:0] key0_q, key1_q;
  logic [FLAG_W-1:0]   flag0_q, flag1_q;

  // Arbitration state: last granted port and a grant held across a stall
  logic rr_last_q;
  logic lock_q;
  logic lock_sel_q;
  logic sel;

  // Reply strobes and statistics
  logic              rsp0_valid_q, rsp1_valid_q;
  logic [FLAG_W-1:0] rsp0_flag_q, rsp1_flag_q;
  logic [CNT_W-1:0]  drop0_q, drop1_q, orphan_q;
  logic              orphan_seen_q;

  // Tag FIFO interface
  logic              tag_full, tag_empty;
  logic [AW:0]       tag_count;
  logic [PORT_W-1:0] tag_head;
  logic [3:0]        tag_count4;

  logic xfer, free0, free1, pop, orphan;

  // A stalled grant stays fixed; otherwise the lone pender wins, or the port not served last
  always_comb begin
    if (lock_q)                 sel = lock_sel_q;
    else if (pend0_q && !pend1_q) sel = 1'b0;
    else if (pend1_q && !pend0_q) sel = 1'b1;
    else                        sel = ~rr_last_q;
  end

  assign db_valid = (pend0_q || pend1_q) && !tag_full;
  assign db_key   = !db_valid ? '0 : (sel ? key1_q  : key0_q);
  assign db_flag  = !db_valid ? '0 : (sel ? flag1_q : flag0_q);

  assign xfer   = db_valid && db_ready;
  assign free0  = xfer && !sel;
  assign free1  = xfer && sel;
  assign pop    = db_rsp_valid && !tag_empty;
  assign orphan = db_rsp_valid && tag_empty;

  kv_tag_fifo #(
    .DEPTH (OUTSTANDING)
  ) u_tag_fifo (
    .clk_i       (clk156),
    .rst_ni      (eth_rst_n),
    .push_i      (xfer),
    .push_data_i (sel),
    .pop_i       (pop),
    .head_o      (tag_head),
    .full_o      (tag_full),
    .empty_o     (tag_empty),
    .count_o     (tag_count)
  );

  // Port-0 slot: capture when idle or being freed this cycle, else count the loss
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      pend0_q <= 1'b0;
      key0_q  <= '0;
      flag0_q <= '0;
      drop0_q <= '0;
    end else begin
      if (req0_valid && (!pend0_q || free0)) begin
        pend0_q <= 1'b1;
        key0_q  <= req0_key;
        flag0_q <= req0_flag;
      end else if (free0) begin
        pend0_q <= 1'b0;
      end
      if (req0_valid && pend0_q && !free0 && (drop0_q != '1)) drop0_q <= drop0_q + 1'b1;
    end
  end

  // Port-1 slot, same policy as port 0
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      pend1_q <= 1'b0;
      key1_q  <= '0;
      flag1_q <= '0;
      drop1_q <= '0;
    end else begin
      if (req1_valid && (!pend1_q || free1)) begin
        pend1_q <= 1'b1;
        key1_q  <= req1_key;
        flag1_q <= req1_flag;
      end else if (free1) begin
        pend1_q <= 1'b0;
      end
      if (req1_valid && pend1_q && !free1 && (drop1_q != '1)) drop1_q <= drop1_q + 1'b1;
    end
  end

  // Round-robin pointer and stall lock; rr_last starts at 1 so port 0 wins first
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rr_last_q  <= 1'b1;
      lock_q     <= 1'b0;
      lock_sel_q <= 1'b0;
    end else begin
      if (xfer) rr_last_q <= sel;
      lock_q     <= db_valid && !db_ready;
      lock_sel_q <= sel;
    end
  end

  // Route each DB reply to the port at the tag FIFO head, one cycle later
  always_ff @(posedge clk156 or negedge eth_rst_n) begin
    if (!eth_rst_n) begin
      rsp0_valid_q  <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp0_flag_q   <= '0;
      rsp1_flag_q   <= '0;
      orphan_q      <= '0;
      orphan_seen_q <= 1'b0;
    end else begin
      rsp0_valid_q <= pop && (tag_head == 1'b0);
      rsp1_valid_q <= pop && (tag_head == 1'b1);
      if (pop && (tag_head == 1'b0)) rsp0_flag_q <= db_rsp_flag;
      if (pop && (tag_head == 1'b1)) rsp1_flag_q <= db_rsp_flag;
      if (orphan) begin
        orphan_seen_q <= 1'b1;
        if (orphan_q != '1) orphan_q <= orphan_q + 1'b1;
      end
    end
  end

  // Fit the tag count into the 4-bit debug field
  generate
    if (AW + 1 >= 4) begin : g_cnt_trunc
      assign tag_count4 = tag_count[3:0];
    end else begin : g_cnt_ext
      assign tag_count4 = {{(3 - AW){1'b0}}, tag_count};
    end
  endgenerate

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_flag  = rsp0_flag_q;
  assign rsp1_flag  = rsp1_flag_q;
  assign drop0_cnt  = drop0_q;
  assign drop1_cnt  = drop1_q;
  assign orphan_cnt = orphan_q;
  assign debug      = {orphan_seen_q, tag_full, pend1_q, pend0_q, tag_count4};

endmodule

// File: doc/kv_req_arbiter.md
Name: kv_req_arbiter

Overview:
- Shares one key-value DB lookup port between two packet parsers (one per 10G port).
- Each parser emits single-cycle, unstallable lookup pulses (key, flag, valid). The block latches each pulse in a per-port pending slot.
- Round-robin arbitration issues pending lookups to the DB with a valid/ready handshake.
- An in-order tag FIFO records the issuing port of each lookup, so DB replies (returned in issue order) go back to the correct parser.

Parameters:
- KEY_SIZE, 96, lookup key width
- OUTSTANDING, 8, max issued-but-unanswered lookups (power of 2, >=2)
- CNT_W, 8, width of the saturating drop/error counters

Ports:
- clk156  in  1  core clock, 156.25 MHz
- eth_rst_n  in  1  asynchronous active-low reset
- req0_key  in  KEY_SIZE  port-0 lookup key
- req0_flag  in  4  port-0 lookup opcode/flag
- req0_valid  in  1  port-0 single-cycle request pulse
- req1_key  in  KEY_SIZE  port-1 lookup key
- req1_flag  in  4  port-1 lookup opcode/flag
- req1_valid  in  1  port-1 single-cycle request pulse
- rsp0_valid  out  1  reply strobe to port 0
- rsp0_flag  out  4  reply flag to port 0
- rsp1_valid  out  1  reply strobe to port 1
- rsp1_flag  out  4  reply flag to port 1
- db_key  out  KEY_SIZE  key to DB
- db_flag  out  4  flag to DB
- db_valid  out  1  request valid to DB
- db_ready  in  1  DB accepts request
- db_rsp_valid  in  1  DB reply strobe (in issue order)
- db_rsp_flag  in  4  DB reply flag
- drop0_cnt  out  CNT_W  port-0 requests lost (slot busy)
- drop1_cnt  out  CNT_W  port-1 requests lost
- orphan_cnt  out  CNT_W  DB replies received with tag FIFO empty
- debug  out  8  {orphan_seen, tag_full, pend1, pend0, tag_count[3:0] (zero-extended, or truncated if wider)}

Behaviour:
- Reset (eth_rst_n low, async):
  - Outputs: pend0/1=0, rr_last=1 (so port 0 wins first), tag FIFO empty, all counters 0, rsp*_valid=0, rsp*_flag=0.
  - Internals: db_key=0 and db_flag=0 whenever db_valid=0.
- Capture:
  - On req_i_valid with pend_i=0: latch key/flag, pend_i<=1.
  - On req_i_valid with pend_i=1 and the slot not freed this cycle: drop the request, drop_i_cnt +1 (saturates at all-ones).
  - If the slot is granted and freed in the same cycle, the new request is captured (no drop).
- Issue (combinational from registers):
  - db_valid = (pend0|pend1) && tag_count<OUTSTANDING.
  - Selection: if only one pending, select it. If both pending, select the port != rr_last.
  - db_key/db_flag are driven from the selected slot.
- Transfer (db_valid && db_ready):
  - Clear the selected pend, rr_last<=selected port, push port id into the tag FIFO.
  - db_key/db_flag stay stable while db_valid=1 and db_ready=0. The selection must not change while stalled; hold the grant until the transfer.
- Latency: req pulse at edge t -> db_valid high in cycle t+1 (when the FIFO is not full).
- Reply:
  - On db_rsp_valid: pop the FIFO head. Next cycle, rsp_head_valid=1 for exactly one cycle and rsp_head_flag=db_rsp_flag. The other port's rsp_valid stays 0.
  - Reply latency is 1 cycle.
- Orphan reply (db_rsp_valid with FIFO empty): no rsp strobe, orphan_cnt +1 (saturating), sticky orphan_seen<=1 (cleared only by reset).
- Push and pop in the same cycle: tag_count unchanged, order preserved. At count=OUTSTANDING a push is not permitted even with a simultaneous pop (db_valid=0 that cycle).
- FIFO pointers: log2(OUTSTANDING) bits, natural wrap; count is log2(OUTSTANDING)+1 bits.
- Reset mid-operation: all state is discarded; late DB replies after reset count as orphans.

Decomposition:
- Shared package kv_pkg:
  - localparams KEY_SIZE_DEF=96 and FLAG_W=4
  - port-id width PORT_W=1
  - status encodings STATUS_SUSPECT=2'b01, STATUS_ARREST=2'b10, STATUS_FILTERE=2'b11
- One sub-module kv_tag_fifo: synchronous FIFO, width PORT_W, depth OUTSTANDING, push/pop/full/empty/count, async active-low reset.

Test Plan:
- Single request: req0_valid at t, key=96'hC0A80164_C0A80162_30390000, flag=4'b0011, db_ready=1 -> db_valid at t+1 with the same key/flag. db_rsp_valid flag=4'b0100 three cycles later -> rsp0_valid one cycle after, flag 4'b0100; rsp1_valid stays 0.
- Simultaneous: req0 and req1 at the same cycle after reset -> port 0 issued first, port 1 next cycle. Replies A then B -> rsp0 gets A, rsp1 gets B.
- Stall/drop: db_ready=0, req0 pulses at t and t+2 -> db_key held stable, second pulse dropped, drop0_cnt=1. Release db_ready -> exactly one issue.
- Backpressure by tags: db_rsp_valid never asserted, 9 alternating requests -> exactly 8 issued. db_valid=0 with debug[6]=1. One reply -> 9th issued the next cycle.
- Orphan: db_rsp_valid with FIFO empty -> no rsp strobes, orphan_cnt=1, debug[7]=1.
- Reset mid-flight: 3 outstanding tags, assert eth_rst_n=0 asynchronously -> all outputs 0 immediately. A later reply increments orphan_cnt to 1.
